// File: rtl/conv_maxpool.sv
// rtl/conv_maxpool.sv - streaming 2x2 stride-1 max-pool stage for the conv engine feature map
//
// Purpose:
//   Consumes an IN_DIM x IN_DIM signed feature map, one sample per in_valid
//   cycle in row-major order. Emits the (IN_DIM-1) x (IN_DIM-1) pooled map on
//   the fly. Only one line buffer row plus two window registers are kept; the
//   frame itself is never stored.
//
// Parameters:
//   DW      signed sample width (input and output)
//   IN_DIM  feature-map side length (>= 2)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data carries the next sample this cycle (no backpressure)
//   in_data    in   signed sample, row-major
//   out_valid  out  out_data holds a new pooled result this cycle
//   out_data   out  signed max of the 2x2 window (held between results)
//   out_last   out  with out_valid: final pooled value of the frame
//   busy       out  frame in progress (FSM not in IDLE)
//
// Configuration:
//   POOL_RELU_EN  when defined, each result is clamped to max(result, 0)
//                 before the output register.

module conv_maxpool #(
  parameter int DW     = 12,
  parameter int IN_DIM = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int CW = (IN_DIM <= 2) ? 1 : $clog2(IN_DIM);
  localparam logic [CW-1:0] LAST_IDX = CW'(IN_DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FIRST_ROW = 2'd1,
    S_POOL      = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]        r_row;
  logic [CW-1:0]        r_col;

  // r_line[c] holds the most recent sample seen in column c, i.e. row r-1
  // until the current row overwrites it at column c.
  logic signed [DW-1:0] r_line [IN_DIM];
  // r_left   = sample (r, c-1)
  // r_upleft = sample (r-1, c-1), captured from the line buffer one accept earlier
  logic signed [DW-1:0] r_left;
  logic signed [DW-1:0] r_upleft;

  logic                 r_out_valid;
  logic signed [DW-1:0] r_out_data;
  logic                 r_out_last;

  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_emit;
  logic signed [DW-1:0] w_up;
  logic signed [DW-1:0] w_max_top;
  logic signed [DW-1:0] w_max_bot;
  logic signed [DW-1:0] w_max;
  logic signed [DW-1:0] w_res;

  function automatic logic signed [DW-1:0] smax(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign w_col_last = (r_col == LAST_IDX);
  assign w_row_last = (r_row == LAST_IDX);
  assign w_emit     = in_valid && (r_row != '0) && (r_col != '0);

  assign w_up      = r_line[r_col];
  assign w_max_top = smax(r_upleft, w_up);
  assign w_max_bot = smax(r_left, in_data);
  assign w_max     = smax(w_max_top, w_max_bot);

`ifdef POOL_RELU_EN
  assign w_res = w_max[DW-1] ? '0 : w_max;
`else
  assign w_res = w_max;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_state_nxt = S_FIRST_ROW;
      end
      S_FIRST_ROW: begin
        if (in_valid && w_col_last) w_state_nxt = S_POOL;
      end
      S_POOL: begin
        if (in_valid && w_col_last && w_row_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Row/column counters; wrapping at the last sample leaves them cleared for
  // the next frame, which may start on the very next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (in_valid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line buffer and window registers. Row 0 overwrites every line-buffer
  // entry before row 1 reads it, so prior-frame contents never reach a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IN_DIM; i++) begin
        r_line[i] <= '0;
      end
      r_left   <= '0;
      r_upleft <= '0;
    end else if (in_valid) begin
      r_line[r_col] <= in_data;
      r_left        <= in_data;
      r_upleft      <= w_up;
    end
  end

  // Registered result; out_data holds its value between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= w_emit;
      r_out_last  <= w_emit && w_row_last && w_col_last;
      if (w_emit) begin
        r_out_data <= w_res;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_conv_maxpool.sv
// tb/tb_conv_maxpool.sv - directed self-checking bench for conv_maxpool

`timescale 1ns/1ps

module tb_conv_maxpool;

  localparam int DW     = 12;
  localparam int IN_DIM = 5;
  localparam int NPIX   = IN_DIM * IN_DIM;
  localparam int NOUT   = (IN_DIM - 1) * (IN_DIM - 1);

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 out_last;
  logic                 busy;

  int n_checks;
  int n_fail;

  logic signed [DW-1:0] stim [64];
  logic signed [DW-1:0] q_data [$];
  logic                 q_last [$];
  logic                 prev_valid;
  int                   n_consec;

  conv_maxpool #(.DW(DW), .IN_DIM(IN_DIM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output collector, sampling on the falling edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
      if (prev_valid) n_consec++;
    end
    prev_valid = (out_valid === 1'b1);
  end

  task automatic clear_capture();
    q_data.delete();
    q_last.delete();
    n_consec = 0;
  endtask

  // Drives stim[0..n-1]; optional one-cycle gap after every sample. Returns
  // 1ns after the edge that accepts the last sample, with in_valid low.
  task automatic drive(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = stim[i];
      if (gaps && i != 0) begin
        // the previous sample was followed by a gap already inserted below
      end
      if (gaps) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_ramp(input int base);
    for (int i = 0; i < NPIX; i++) stim[base + i] = DW'(i);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    idle(3);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (out_data !== 12'h000) begin n_fail++; $display("FAIL reset_out_data got=%h exp=000", out_data); end
    n_checks++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    clear_capture();
  endtask

  task automatic test_ramp();
    logic signed [DW-1:0] e;
    clear_capture();
    load_ramp(0);
    drive(NPIX, 1'b0);
    // 1ns after the edge accepting (4,4): last result present, frame over
    n_checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== 12'sd24) begin
      n_fail++;
      $display("FAIL ramp_final got v=%b l=%b d=%0d exp v=1 l=1 d=24", out_valid, out_last, out_data);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ramp_busy_after got=%b exp=0", busy); end
    idle(3);
    n_checks++;
    if (q_data.size() != NOUT) begin
      n_fail++; $display("FAIL ramp_count got=%0d exp=%0d", q_data.size(), NOUT);
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        e = DW'(5 * (i / 4 + 1) + (i % 4 + 1));
        n_checks++;
        if (q_data[i] !== e || q_last[i] !== (i == NOUT - 1)) begin
          n_fail++;
          $display("FAIL ramp_out[%0d] got d=%0d l=%b exp d=%0d l=%b", i, q_data[i], q_last[i], e, (i == NOUT - 1));
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic signed [DW-1:0] e;
    clear_capture();
    load_ramp(0);
    drive(NPIX, 1'b1);
    idle(3);
    n_checks++;
    if (n_consec != 0) begin n_fail++; $display("FAIL gaps_consecutive got=%0d exp=0", n_consec); end
    n_checks++;
    if (q_data.size() != NOUT) begin
      n_fail++; $display("FAIL gaps_count got=%0d exp=%0d", q_data.size(), NOUT);
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        e = DW'(5 * (i / 4 + 1) + (i % 4 + 1));
        n_checks++;
        if (q_data[i] !== e) begin
          n_fail++; $display("FAIL gaps_out[%0d] got=%0d exp=%0d", i, q_data[i], e);
        end
      end
    end
  endtask

  task automatic test_negative();
    logic signed [DW-1:0] e;
`ifdef POOL_RELU_EN
    e = 12'h000;
`else
    e = 12'hFFB;
`endif
    clear_capture();
    for (int i = 0; i < NPIX; i++) stim[i] = -12'sd5;
    drive(NPIX, 1'b0);
    idle(3);
    n_checks++;
    if (q_data.size() != NOUT) begin
      n_fail++; $display("FAIL neg_count got=%0d exp=%0d", q_data.size(), NOUT);
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        n_checks++;
        if (q_data[i] !== e) begin
          n_fail++; $display("FAIL neg_out[%0d] got=%h exp=%h", i, q_data[i], e);
        end
      end
    end
  endtask

  task automatic test_extremes();
    logic signed [DW-1:0] e;
    clear_capture();
    for (int i = 0; i < NPIX; i++) stim[i] = '0;
    stim[0] = 12'h800;
    stim[1] = 12'h7FF;
    stim[5] = 12'hFFF;
    stim[6] = 12'h000;
    drive(NPIX, 1'b0);
    idle(3);
    n_checks++;
    if (q_data.size() < 1 || q_data[0] !== 12'h7FF) begin
      n_fail++; $display("FAIL ext_first got=%h exp=7ff", (q_data.size() > 0) ? q_data[0] : 12'hxxx);
    end
`ifdef POOL_RELU_EN
    e = 12'h000;
`else
    e = 12'h800;
`endif
    clear_capture();
    for (int i = 0; i < NPIX; i++) stim[i] = 12'h800;
    drive(NPIX, 1'b0);
    idle(3);
    n_checks++;
    if (q_data.size() != NOUT) begin
      n_fail++; $display("FAIL ext_min_count got=%0d exp=%0d", q_data.size(), NOUT);
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        n_checks++;
        if (q_data[i] !== e) begin
          n_fail++; $display("FAIL ext_min_out[%0d] got=%h exp=%h", i, q_data[i], e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [DW-1:0] e;
    int n_last;
    clear_capture();
    load_ramp(0);
    for (int i = 0; i < NPIX; i++) stim[NPIX + i] = DW'(24 - i);
    drive(2 * NPIX, 1'b0);
    idle(3);
    n_last = 0;
    foreach (q_last[i]) if (q_last[i]) n_last++;
    n_checks++;
    if (n_last != 2) begin n_fail++; $display("FAIL b2b_last_count got=%0d exp=2", n_last); end
    n_checks++;
    if (q_data.size() != 2 * NOUT) begin
      n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", q_data.size(), 2 * NOUT);
    end else begin
      n_checks++;
      if (q_data[NOUT] !== 12'sd24) begin
        n_fail++; $display("FAIL b2b_second_first got=%0d exp=24", q_data[NOUT]);
      end
      for (int i = 0; i < NOUT; i++) begin
        // reversed ramp: window max is its top-left sample
        e = DW'(24 - 5 * (i / 4) - (i % 4));
        n_checks++;
        if (q_data[NOUT + i] !== e || q_last[NOUT + i] !== (i == NOUT - 1)) begin
          n_fail++;
          $display("FAIL b2b_out[%0d] got d=%0d l=%b exp d=%0d l=%b", NOUT + i, q_data[NOUT + i], q_last[NOUT + i], e, (i == NOUT - 1));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic signed [DW-1:0] e;
    clear_capture();
    for (int i = 0; i < 12; i++) stim[i] = DW'(100 + i);
    drive(12, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 12'h000) begin
      n_fail++; $display("FAIL mid_reset_outputs got b=%b v=%b d=%h exp b=0 v=0 d=000", busy, out_valid, out_data);
    end
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    clear_capture();
    load_ramp(0);
    drive(NPIX, 1'b0);
    idle(3);
    n_checks++;
    if (q_data.size() != NOUT) begin
      n_fail++; $display("FAIL mid_count got=%0d exp=%0d", q_data.size(), NOUT);
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        e = DW'(5 * (i / 4 + 1) + (i % 4 + 1));
        n_checks++;
        if (q_data[i] !== e) begin
          n_fail++; $display("FAIL mid_out[%0d] got=%0d exp=%0d", i, q_data[i], e);
        end
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    prev_valid = 1'b0;
    n_consec   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    test_reset();
    test_ramp();
    test_gaps();
    test_negative();
    test_extremes();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
